// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl
// -------------
// Bring-up and supervision controller for an STDPLLX-style PLL. It pulses the
// PLL reset, waits for lock with a timeout and a bounded number of retries,
// qualifies lock over a run of consecutive cycles before declaring it ready,
// gates the downstream clock enable, and restarts the PLL after lock loss.
// Everything runs in the PLL reference-clock domain.
//
// Ports:
//   clk        in   PLL reference clock, sole clock
//   rst        in   asynchronous active-high reset
//   en         in   bring-up request (level)
//   pll_lock   in   raw PLL lock, asynchronous to clk
//   clken_in   in   raw downstream clock enable
//   pll_rst    out  PLL reset (high while idle, resetting or failed)
//   clken_out  out  clken_in gated by ready, registered
//   ready      out  PLL locked and qualified
//   fail       out  sticky bring-up failure, cleared by dropping en
//   lock_lost  out  one-cycle pulse when lock drops while running
//   retry_cnt  out  retries used in the current bring-up
//   lost_cnt   out  lock-loss events since reset, saturating at 255
//   state      out  IDLE=0 RESET=1 WAIT_LOCK=2 STABLE=3 RUN=4 FAIL=5
module pll_lock_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 1000,
    parameter int STABLE_CYCLES = 64,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       pll_lock,
    input  logic       clken_in,
    output logic       pll_rst,
    output logic       clken_out,
    output logic       ready,
    output logic       fail,
    output logic       lock_lost,
    output logic [2:0] retry_cnt,
    output logic [7:0] lost_cnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [2:0]       RETRY_LAST   = 3'(MAX_RETRY);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             pll_rst_q, pll_rst_d;
    logic             clken_out_q, clken_out_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;
    logic             lock_lost_q, lock_lost_d;
    logic [2:0]       retry_cnt_q, retry_cnt_d;
    logic [7:0]       lost_cnt_q, lost_cnt_d;
    logic             lock_s;
    logic             lost_event;

    assign lock_s = sync2_q;

    // Next-state logic. Dropping en overrides every other transition and
    // also suppresses a lock-loss event that would otherwise be reported in
    // the same cycle. The registered outputs are all decoded from the next
    // state so they change on the same edge as the state itself.
    always_comb begin
        sync1_d     = pll_lock;
        sync2_d     = sync1_q;
        state_d     = state_q;
        retry_cnt_d = retry_cnt_q;
        lost_cnt_d  = lost_cnt_q;
        lost_event  = 1'b0;

        if (!en) begin
            state_d     = ST_IDLE;
            retry_cnt_d = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_RESET;
                ST_RESET: begin
                    if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    // A lock seen on the timeout cycle still wins.
                    if (lock_s) begin
                        state_d = ST_STABLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        if (retry_cnt_q == RETRY_LAST) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d     = ST_RESET;
                            retry_cnt_d = retry_cnt_q + 3'd1;
                        end
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d     = ST_RUN;
                        retry_cnt_d = 3'd0;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_d    = ST_RESET;
                        lost_event = 1'b1;
                        if (lost_cnt_q != 8'hFF) lost_cnt_d = lost_cnt_q + 8'd1;
                    end
                end
                ST_FAIL: state_d = ST_FAIL;
                default: state_d = ST_IDLE;
            endcase
        end

        // The shared counter restarts on every state entry, including the
        // STABLE -> WAIT_LOCK fallback, so the timeout is measured afresh.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == ST_RESET || state_q == ST_WAIT_LOCK ||
                     state_q == ST_STABLE) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
        end

        pll_rst_d   = (state_d == ST_IDLE) || (state_d == ST_RESET) ||
                      (state_d == ST_FAIL);
        ready_d     = (state_d == ST_RUN);
        clken_out_d = (state_d == ST_RUN) && clken_in;
        fail_d      = (state_d == ST_FAIL);
        lock_lost_d = lost_event;
    end

    // All state and outputs; pll_rst comes up high as soon as rst asserts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            pll_rst_q   <= 1'b1;
            clken_out_q <= 1'b0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
            lock_lost_q <= 1'b0;
            retry_cnt_q <= 3'd0;
            lost_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            pll_rst_q   <= pll_rst_d;
            clken_out_q <= clken_out_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
            lock_lost_q <= lock_lost_d;
            retry_cnt_q <= retry_cnt_d;
            lost_cnt_q  <= lost_cnt_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign clken_out = clken_out_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign lock_lost = lock_lost_q;
    assign retry_cnt = retry_cnt_q;
    assign lost_cnt  = lost_cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// tb_pll_lock_ctrl
// ----------------
// Directed bench for pll_lock_ctrl with short timing parameters
// (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2).
// Inputs change and outputs are read 1 ns after each rising clock edge.
module tb_pll_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       pll_lock;
    logic       clken_in;
    logic       pll_rst;
    logic       clken_out;
    logic       ready;
    logic       fail;
    logic       lock_lost;
    logic [2:0] retry_cnt;
    logic [7:0] lost_cnt;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    pll_lock_ctrl #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .MAX_RETRY    (2),
        .CNT_W        (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .pll_lock (pll_lock),
        .clken_in (clken_in),
        .pll_rst  (pll_rst),
        .clken_out(clken_out),
        .ready    (ready),
        .fail     (fail),
        .lock_lost(lock_lost),
        .retry_cnt(retry_cnt),
        .lost_cnt (lost_cnt),
        .state    (state)
    );

    // 10 ns reference clock.
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en_v, input logic lock_v, input logic clken_v);
        en       = en_v;
        pll_lock = lock_v;
        clken_in = clken_v;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_pll_rst"},   32'(pll_rst),   32'd1);
        checkOutput({tag, "_clken_out"}, 32'(clken_out), 32'd0);
        checkOutput({tag, "_ready"},     32'(ready),     32'd0);
        checkOutput({tag, "_fail"},      32'(fail),      32'd0);
        checkOutput({tag, "_lock_lost"}, 32'(lock_lost), 32'd0);
        checkOutput({tag, "_retry_cnt"}, 32'(retry_cnt), 32'd0);
        checkOutput({tag, "_lost_cnt"},  32'(lost_cnt),  32'd0);
        checkOutput({tag, "_state"},     32'(state),     32'd0);
    endtask

    // Hard stop in case a wait loop is ever left unbounded.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int misses;
        int t;
        int exp_state;
        int exp_retry;
        int exp_prst;

        // ---------------- reset values ----------------
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        #12;
        checkResetValues("por");
        step(1);
        rst = 1'b0;
        step(2);
        checkOutput("idle_state", 32'(state), 32'd0);
        checkOutput("idle_pll_rst", 32'(pll_rst), 32'd1);

        // ---------------- normal bring-up ----------------
        applyStimulus(1'b1, 1'b0, 1'b0);
        step(1);
        checkOutput("bring_reset_state", 32'(state), 32'd1);
        n = 0;
        while (state == 3'd1 && n < 50) begin
            if (pll_rst !== 1'b1) n = 100;
            n++;
            step(1);
        end
        checkOutput("bring_reset_len", 32'(n), 32'd4);
        checkOutput("bring_wait_state", 32'(state), 32'd2);
        checkOutput("bring_wait_pll_rst", 32'(pll_rst), 32'd0);
        step(5);
        applyStimulus(1'b1, 1'b1, 1'b0);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!ready && n < 40);
        checkOutput("bring_lock_to_ready", 32'(n), 32'd11);
        checkOutput("bring_run_state", 32'(state), 32'd4);
        checkOutput("bring_retry", 32'(retry_cnt), 32'd0);
        checkOutput("bring_clken_low", 32'(clken_out), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("clken_latency", 32'(clken_out), 32'd0);
        step(1);
        checkOutput("clken_hi", 32'(clken_out), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        step(1);
        checkOutput("clken_lo", 32'(clken_out), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        step(1);
        checkOutput("clken_hi2", 32'(clken_out), 32'd1);

        // ---------------- lock loss in RUN ----------------
        applyStimulus(1'b1, 1'b0, 1'b1);
        step(2);
        checkOutput("loss_e2_ready", 32'(ready), 32'd1);
        checkOutput("loss_e2_clken", 32'(clken_out), 32'd1);
        checkOutput("loss_e2_lock_lost", 32'(lock_lost), 32'd0);
        step(1);
        checkOutput("loss_e3_clken", 32'(clken_out), 32'd0);
        checkOutput("loss_e3_ready", 32'(ready), 32'd0);
        checkOutput("loss_e3_lock_lost", 32'(lock_lost), 32'd1);
        checkOutput("loss_e3_lost_cnt", 32'(lost_cnt), 32'd1);
        checkOutput("loss_e3_state", 32'(state), 32'd1);
        step(1);
        checkOutput("loss_pulse_end", 32'(lock_lost), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        n = 0;
        while (!ready && n < 60) begin
            step(1);
            n++;
        end
        checkOutput("relock_state", 32'(state), 32'd4);

        // ---------------- en drop beats lock loss ----------------
        applyStimulus(1'b1, 1'b0, 1'b1);
        step(2);
        checkOutput("prio_pre_state", 32'(state), 32'd4);
        applyStimulus(1'b0, 1'b0, 1'b1);
        step(1);
        checkOutput("prio_state", 32'(state), 32'd0);
        checkOutput("prio_lock_lost", 32'(lock_lost), 32'd0);
        checkOutput("prio_ready", 32'(ready), 32'd0);
        checkOutput("prio_clken", 32'(clken_out), 32'd0);
        checkOutput("prio_lost_cnt", 32'(lost_cnt), 32'd1);
        checkOutput("prio_pll_rst", 32'(pll_rst), 32'd1);

        // ---------------- lost_cnt saturation ----------------
        applyStimulus(1'b1, 1'b1, 1'b1);
        n = 0;
        while (!ready && n < 60) begin
            step(1);
            n++;
        end
        checkOutput("sat_start_ready", 32'(ready), 32'd1);
        misses = 0;
        for (int i = 0; i < 259; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            n = 0;
            do begin
                step(1);
                n++;
            end while (!lock_lost && n < 10);
            if (!lock_lost) misses++;
            applyStimulus(1'b1, 1'b1, 1'b1);
            n = 0;
            while (!ready && n < 60) begin
                step(1);
                n++;
            end
            if (!ready) misses++;
        end
        checkOutput("sat_wait_misses", 32'(misses), 32'd0);
        checkOutput("sat_lost_cnt", 32'(lost_cnt), 32'd255);

        // ---------------- glitch during STABLE, after one retry ----------------
        applyStimulus(1'b0, 1'b0, 1'b0);
        step(1);
        checkOutput("glitch_idle", 32'(state), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        n = 0;
        while (!(retry_cnt == 3'd1 && state == 3'd2) && n < 80) begin
            step(1);
            n++;
        end
        checkOutput("glitch_retry1", 32'(retry_cnt), 32'd1);
        checkOutput("glitch_wait", 32'(state), 32'd2);
        applyStimulus(1'b1, 1'b1, 1'b0);
        n = 0;
        while (state != 3'd3 && n < 10) begin
            step(1);
            n++;
        end
        checkOutput("glitch_to_stable", 32'(n), 32'd3);
        step(4);
        applyStimulus(1'b1, 1'b0, 1'b0);
        step(3);
        checkOutput("glitch_back_wait", 32'(state), 32'd2);
        checkOutput("glitch_ready", 32'(ready), 32'd0);
        checkOutput("glitch_retry_kept", 32'(retry_cnt), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!ready && n < 40);
        checkOutput("glitch_requal", 32'(n), 32'd11);
        checkOutput("glitch_retry_clear", 32'(retry_cnt), 32'd0);

        // ---------------- no lock: retries then FAIL ----------------
        applyStimulus(1'b0, 1'b0, 1'b0);
        step(1);
        checkOutput("nolock_idle", 32'(state), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 80; k++) begin
            step(1);
            t = k;
            if (t < 72) begin
                exp_state = ((t % 24) < 4) ? 1 : 2;
                exp_prst  = ((t % 24) < 4) ? 1 : 0;
                exp_retry = t / 24;
            end else begin
                exp_state = 5;
                exp_prst  = 1;
                exp_retry = 2;
            end
            checkOutput($sformatf("nolock_state_t%0d", t), 32'(state), 32'(exp_state));
            checkOutput($sformatf("nolock_pll_rst_t%0d", t), 32'(pll_rst), 32'(exp_prst));
            checkOutput($sformatf("nolock_retry_t%0d", t), 32'(retry_cnt), 32'(exp_retry));
        end
        checkOutput("nolock_fail", 32'(fail), 32'd1);
        checkOutput("nolock_ready", 32'(ready), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        step(1);
        checkOutput("nolock_clear_state", 32'(state), 32'd0);
        checkOutput("nolock_clear_fail", 32'(fail), 32'd0);
        checkOutput("nolock_clear_retry", 32'(retry_cnt), 32'd0);

        // ---------------- async reset during WAIT_LOCK ----------------
        applyStimulus(1'b1, 1'b0, 1'b0);
        n = 0;
        while (state != 3'd2 && n < 20) begin
            step(1);
            n++;
        end
        step(2);
        checkOutput("arst_pre_pll_rst", 32'(pll_rst), 32'd0);
        checkOutput("arst_pre_lost_cnt", 32'(lost_cnt), 32'd255);
        #3;
        rst = 1'b1;
        #1;
        checkResetValues("arst");
        step(1);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        step(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
